apb_ram_arbiter: RTL and testbench

Round-robin APB master that shares one APB slave (the 32-word APB RAM) among `NREQ` requesters. Each requester issues a single read or write over a simple req/done handshake. The arbiter grants one requester at a time, runs a full APB SETUP→ACCESS transfer, and returns read data and error status with a one-cycle done pulse. It sits between the requester blocks and the RAM's APB slave port.

---
 rtl/apb_ram_arbiter_pkg.sv | 16 +
 rtl/apb_ram_arbiter_if.sv | 28 ++
 rtl/apb_ram_arbiter_rr.sv | 37 +++
 rtl/apb_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_ram_arbiter_pkg.sv
// apb_ram_arbiter_pkg: shared types and default widths for the APB RAM arbiter.
//   arb_state_t : transfer FSM state (IDLE, SETUP, ACCESS, COMPLETE)
//   APB_AW/APB_DW : default APB address/data widths
package apb_ram_arbiter_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/apb_ram_arbiter_if.sv
// apb_ram_arbiter_if: APB bus between the arbiter (master) and the RAM (slave).
//   o_psel/o_penable/o_pwrite/o_paddr/o_pwdata : driven by the master
//   i_prdata/i_pready/i_pslverr                : driven by the slave
interface apb_ram_arbiter_if
  import apb_ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = APB_AW,
  parameter int unsigned DW = APB_DW
);
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [DW-1:0] o_pwdata;
  logic [DW-1:0] i_prdata;
  logic          i_pready;
  logic          i_pslverr;

  modport master (
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    input  i_prdata, i_pready, i_pslverr
  );

  modport slave (
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
    output i_prdata, i_pready, i_pslverr
  );
endinterface

// File: rtl/apb_ram_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   i_req     : request vector
//   i_ptr     : highest-priority index
//   o_grant_c : one-hot grant of the first set request at or after i_ptr
//   o_idx_c   : index of that grant
//   o_valid_c : any request set
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant_c,
  output logic [$clog2(NREQ)-1:0] o_idx_c,
  output logic                    o_valid_c
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned KW = IW + 1;

  logic [KW-1:0] w_k;

  // Scan from the pointer, wrapping modulo NREQ; first hit wins.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_k       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = {1'b0, i_ptr} + KW'(i);
      if (w_k >= KW'(NREQ)) w_k = w_k - KW'(NREQ);
      if (!o_valid_c && i_req[w_k[IW-1:0]]) begin
        o_valid_c               = 1'b1;
        o_idx_c                 = w_k[IW-1:0];
        o_grant_c[w_k[IW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: round-robin APB master sharing one APB RAM among NREQ requesters.
//   i_pclk, i_presetn : clock, synchronous active-low reset
//   i_req/i_wr        : per-requester request level and direction
//   i_addr/i_wdata    : packed per-requester address/write data (k*W +: W)
//   o_done            : one-hot one-cycle completion pulse
//   o_rdata/o_err     : completion read data and error, valid with o_done
//   apb               : APB master port
// Optional: define APB_RAM_ARBITER_TIMEOUT_EN to abort ACCESS after TIMEOUT
// stalled cycles with an error completion.
module apb_ram_arbiter
  import apb_ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               i_pclk,
  input  logic               i_presetn,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_wr,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  output logic [NREQ-1:0]    o_done,
  output logic [DW-1:0]      o_rdata,
  output logic               o_err,
  apb_ram_arbiter_if.master  apb
);
  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0) begin : g_param_check
    $error("apb_ram_arbiter: NREQ must be 2..8 and TIMEOUT nonzero");
  end

  arb_state_t      r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt, r_gnt_idx, w_pick_idx;
  logic [NREQ-1:0] r_gnt_oh, w_pick_oh, r_done, w_done_nxt;
  logic            w_pick_valid, w_latch, w_tmo_hit;
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_psel, w_psel_nxt, r_penable, w_penable_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic            r_err, w_err_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req     (i_req),
    .i_ptr     (r_rr_ptr),
    .o_grant_c (w_pick_oh),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

`ifdef APB_RAM_ARBITER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Counts stalled ACCESS cycles; cleared in SETUP so it starts at 0 in ACCESS.
  always_ff @(posedge i_pclk) begin
    if (!i_presetn)                                r_tmo_cnt <= '0;
    else if (r_state == ST_SETUP)                  r_tmo_cnt <= '0;
    else if (r_state == ST_ACCESS && !apb.i_pready) r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  // This stalled cycle is the TIMEOUT-th one.
  assign w_tmo_hit = (r_state == ST_ACCESS) && !apb.i_pready &&
                     (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_latch       = 1'b0;
    w_psel_nxt    = 1'b0;
    w_penable_nxt = 1'b0;
    w_done_nxt    = '0;
    w_rdata_nxt   = '0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_SETUP;
          w_psel_nxt  = 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (apb.i_pready) begin
          w_state_nxt = ST_COMPLETE;
          w_done_nxt  = r_gnt_oh;
          w_rdata_nxt = r_wr ? '0 : apb.i_prdata;
          w_err_nxt   = apb.i_pslverr;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_COMPLETE;
          w_done_nxt  = r_gnt_oh;
          w_err_nxt   = 1'b1;
        end else begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b1;
        end
      end
      ST_COMPLETE: begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + IW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pointer, request latches and output registers.
  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_gnt_oh  <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      if (w_latch) begin
        r_gnt_idx <= w_pick_idx;
        r_gnt_oh  <= w_pick_oh;
        r_wr      <= i_wr[w_pick_idx];
        r_addr    <= i_addr[w_pick_idx * AW +: AW];
        r_wdata   <= i_wdata[w_pick_idx * DW +: DW];
      end
    end
  end

  assign o_done        = r_done;
  assign o_rdata       = r_rdata;
  assign o_err         = r_err;
  assign apb.o_psel    = r_psel;
  assign apb.o_penable = r_penable;
  assign apb.o_pwrite  = r_wr;
  assign apb.o_paddr   = r_addr;
  assign apb.o_pwdata  = r_wdata;
endmodule

// File: tb/tb_apb_ram_arbiter.sv
// tb_apb_ram_arbiter: directed and randomized checks of apb_ram_arbiter against
// a transaction-level model (array RAM + round-robin order + fixed latencies).
module tb_apb_ram_arbiter;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned RAM_WORDS = 32;
  // Request to done: SETUP, two ACCESS cycles (RAM has one wait state), COMPLETE.
  localparam int LAT_FIRST = 4;
  // Following done: COMPLETE and IDLE of the previous, then the same 4-cycle path
  // starting one IDLE cycle later.
  localparam int LAT_NEXT  = 5;
  // SETUP, 16 stalled ACCESS cycles, COMPLETE.
  localparam int LAT_TMO   = 18;
  localparam int WAIT_MAX  = 60;

  logic                 clk = 1'b0;
  logic                 presetn = 1'b0;
  logic [NREQ-1:0]      req = '0, wr = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic [NREQ-1:0]      done;
  logic [DW-1:0]        rdata;
  logic                 err;

  apb_ram_arbiter_if #(.AW(AW), .DW(DW)) apb ();

  apb_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .i_pclk    (clk),
    .i_presetn (presetn),
    .i_req     (req),
    .i_wr      (wr),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_done    (done),
    .o_rdata   (rdata),
    .o_err     (err),
    .apb       (apb)
  );

  always #5 clk = ~clk;

  // APB RAM slave: one wait state, error on addresses beyond RAM_WORDS.
  logic [31:0] mem [RAM_WORDS];
  logic        slv_wait_done = 1'b0;
  logic        slv_stall = 1'b0;
  logic        slv_init_done = 1'b0;

  assign apb.i_pready  = apb.o_psel && apb.o_penable && slv_wait_done && !slv_stall;
  assign apb.i_pslverr = apb.i_pready && (apb.o_paddr >= RAM_WORDS);
  assign apb.i_prdata  = (apb.o_paddr < RAM_WORDS) ? mem[apb.o_paddr[4:0]] : '0;

  always @(posedge clk) begin
    if (!slv_init_done) begin
      for (int i = 0; i < int'(RAM_WORDS); i++) mem[i] <= '0;
      slv_init_done <= 1'b1;
    end else if (apb.i_pready && apb.o_pwrite && apb.o_paddr < RAM_WORDS) begin
      mem[apb.o_paddr[4:0]] <= apb.o_pwdata;
    end
    slv_wait_done <= apb.o_psel && apb.o_penable && !apb.i_pready;
  end

  // Reference model state.
  logic [31:0] ref_mem [RAM_WORDS];
  int          ref_ptr = 0;
  logic        t_wr   [NREQ];
  logic [31:0] t_addr [NREQ];
  logic [31:0] t_data [NREQ];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int next_grant(input logic [NREQ-1:0] pend, input int ptr);
    for (int i = 0; i < int'(NREQ); i++) begin
      int k;
      k = (ptr + i) % int'(NREQ);
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic apply_reqs(input logic [NREQ-1:0] mask);
    for (int k = 0; k < int'(NREQ); k++) begin
      req[k]              = mask[k];
      wr[k]               = t_wr[k];
      addr[k*AW +: AW]    = t_addr[k];
      wdata[k*DW +: DW]   = t_data[k];
    end
  endtask

  // Issue all requests in mask at once (DUT idle) and check every completion.
  task automatic run_round(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] exp_oh;
    logic [31:0]     exp_rd;
    logic            exp_err;
    int              k, waited;
    bit              first;
    pend  = mask;
    first = 1'b1;
    apply_reqs(mask);
    while (pend != '0) begin
      k = next_grant(pend, ref_ptr);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (done == '0 && waited < WAIT_MAX);
      chk(first ? "latency_first" : "latency_next", 32'(waited), first ? 32'(LAT_FIRST) : 32'(LAT_NEXT));
      first  = 1'b0;
      exp_oh = '0;
      exp_oh[k] = 1'b1;
      if (t_addr[k] >= RAM_WORDS) begin
        exp_rd = '0; exp_err = 1'b1;
      end else if (t_wr[k]) begin
        exp_rd = '0; exp_err = 1'b0;
        ref_mem[t_addr[k][4:0]] = t_data[k];
      end else begin
        exp_rd = ref_mem[t_addr[k][4:0]]; exp_err = 1'b0;
      end
      chk("done_onehot", 32'(done), 32'(exp_oh));
      chk("rdata", rdata, exp_rd);
      chk("err", 32'(err), 32'(exp_err));
      chk("psel_in_done", 32'(apb.o_psel), 32'd0);
      ref_ptr = (k + 1) % int'(NREQ);
      pend[k] = 1'b0;
      req[k]  = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] m;
    int              seen, waited;
    for (int i = 0; i < int'(RAM_WORDS); i++) ref_mem[i] = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      t_wr[k] = 1'b0; t_addr[k] = '0; t_data[k] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_psel", 32'(apb.o_psel), 32'd0);
    chk("rst_penable", 32'(apb.o_penable), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_paddr", apb.o_paddr, 32'd0);
    presetn = 1'b1;
    @(negedge clk);

    // Simultaneous writes from all requesters: order 0,1,2,3.
    for (int k = 0; k < int'(NREQ); k++) begin
      t_wr[k] = 1'b1; t_addr[k] = 32'(k); t_data[k] = 32'h100 + 32'(k);
    end
    run_round(4'b1111);

    // Write then read back on requester 0.
    t_wr[0] = 1'b1; t_addr[0] = 32'd5; t_data[0] = 32'hDEAD_BEEF;
    run_round(4'b0001);
    t_wr[0] = 1'b0;
    run_round(4'b0001);

    // Read back the simultaneous writes.
    for (int k = 0; k < int'(NREQ); k++) begin
      t_wr[k] = 1'b0; t_addr[k] = 32'(k);
    end
    run_round(4'b1111);

    // Round robin: after requester 2, requester 3 outranks requester 0.
    t_wr[2] = 1'b0; t_addr[2] = 32'd1;
    run_round(4'b0100);
    t_wr[0] = 1'b0; t_addr[0] = 32'd2;
    t_wr[3] = 1'b0; t_addr[3] = 32'd3;
    run_round(4'b1001);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        t_wr[k]   = 1'($urandom_range(0, 1));
        t_addr[k] = 32'($urandom_range(0, 35));
        t_data[k] = $urandom;
      end
      m = NREQ'($urandom_range(1, 15));
      run_round(m);
    end

    // Out-of-range read on requester 1.
    t_wr[1] = 1'b0; t_addr[1] = 32'd40;
    run_round(4'b0010);

    // Reset during ACCESS: transfer lost, no done, pointer back to 0.
    t_wr[2] = 1'b1; t_addr[2] = 32'd7; t_data[2] = 32'hBAD0_0007;
    apply_reqs(4'b0100);
    @(negedge clk);
    @(negedge clk);
    chk("access_psel", 32'(apb.o_psel), 32'd1);
    chk("access_penable", 32'(apb.o_penable), 32'd1);
    presetn = 1'b0;
    req     = '0;
    @(negedge clk);
    chk("mid_rst_psel", 32'(apb.o_psel), 32'd0);
    chk("mid_rst_penable", 32'(apb.o_penable), 32'd0);
    seen = (done != '0) ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    presetn = 1'b1;
    @(negedge clk);
    if (done != '0) seen++;
    chk("done_across_reset", 32'(seen), 32'd0);
    ref_ptr = 0;
    t_wr[0] = 1'b0; t_addr[0] = 32'd7;
    for (int k = 1; k < int'(NREQ); k++) begin
      t_wr[k] = 1'b0; t_addr[k] = 32'(k + 10);
    end
    run_round(4'b1111);

    // Slave never ready.
    slv_stall = 1'b1;
    t_wr[0] = 1'b0; t_addr[0] = 32'd1;
    apply_reqs(4'b0001);
`ifdef APB_RAM_ARBITER_TIMEOUT_EN
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (done == '0 && waited < WAIT_MAX);
    chk("tmo_latency", 32'(waited), 32'(LAT_TMO));
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_rdata", rdata, 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
`else
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    chk("stall_no_done", 32'(seen), 32'd0);
    chk("stall_psel_held", 32'(apb.o_psel), 32'd1);
    chk("stall_penable_held", 32'(apb.o_penable), 32'd1);
    req = '0;
    presetn = 1'b0;
    repeat (2) @(negedge clk);
    presetn = 1'b1;
`endif
    slv_stall = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
